// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin arbiter that grants one of three rectangle requesters and scans its pixels onto the VGA plot port
//   clk, reset              : clock and synchronous active-high reset
//   req, req_x/y/w/h/colour : per-requester request and packed rectangle fields
//   pause                   : stalls the pixel scan while high
//   gnt, done               : one-cycle one-hot grant / completion pulses
//   busy                    : high whenever not idle
//   vga_x/y/colour/plot     : pixel write port to the adapter
module draw_arbiter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] req_x,
    input  logic [20:0] req_y,
    input  logic [23:0] req_w,
    input  logic [20:0] req_h,
    input  logic [8:0]  req_colour,
    input  logic        pause,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic        busy,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot
);
    typedef enum logic [1:0] {IDLE, GRANT, FILL, DONE} state_t;
    localparam logic [8:0] X_LIM = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM = 8'(SCREEN_H);
    state_t state;
    logic [1:0] ptr, sel, p1, p2, win;
    logic [7:0] x0, w0, cx;
    logic [6:0] y0, h0, cy;
    logic [2:0] col;
    logic [8:0] sx;
    logic [7:0] sy;
    logic fill;
    // Search order ptr, ptr+1, ptr+2 (mod 3); p2 is the last resort
    always_comb begin
        p1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        p2 = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
        win = req[ptr] ? ptr : req[p1] ? p1 : p2;
        sx = {1'b0, x0} + {1'b0, cx};
        sy = {1'b0, y0} + {1'b0, cy};
        fill = (state == FILL);
        vga_x = fill ? sx[7:0] : '0;
        vga_y = fill ? sy[6:0] : '0;
        vga_colour = fill ? col : '0;
        // Off-screen pixels still take their cycle, they just never strobe
        vga_plot = fill && !pause && !reset && (sx < X_LIM) && (sy < Y_LIM);
    end
    assign gnt = {3{state == GRANT}} & (3'b001 << sel);
    assign done = {3{state == DONE}} & (3'b001 << sel);
    assign busy = (state != IDLE);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr <= '0;
            sel <= '0;
            cx <= '0;
            cy <= '0;
            x0 <= '0;
            y0 <= '0;
            w0 <= '0;
            h0 <= '0;
            col <= '0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    sel <= win;
                    x0 <= req_x[8*win +: 8];
                    y0 <= req_y[7*win +: 7];
                    w0 <= req_w[8*win +: 8];
                    h0 <= req_h[7*win +: 7];
                    col <= req_colour[3*win +: 3];
                    state <= GRANT;
                end
                GRANT: begin
                    cx <= '0;
                    cy <= '0;
                    ptr <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
                    state <= (w0 == 8'd0 || h0 == 7'd0) ? DONE : FILL;
                end
                FILL: if (!pause) begin
                    if (cx == w0 - 8'd1) begin
                        cx <= '0;
                        cy <= cy + 7'd1;
                        if (cy == h0 - 7'd1) state <= DONE;
                    end else begin
                        cx <= cx + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_draw_arbiter.sv
// tb_draw_arbiter: directed self-checking bench for draw_arbiter
module tb_draw_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [23:0] req_w;
    logic [20:0] req_h;
    logic [8:0]  req_colour;
    logic        pause;
    logic [2:0]  gnt, done;
    logic        busy;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    int vectors = 0;
    int miscompares = 0;
    int px[16], py[16], pc[16];
    int nplots, ncycles;
    draw_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
        .req_w(req_w), .req_h(req_h), .req_colour(req_colour), .pause(pause),
        .gnt(gnt), .done(done), .busy(busy), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic set_req(input int i, input int x, input int y, input int w, input int h, input int c);
        req_x[8*i +: 8] = x[7:0];
        req_y[7*i +: 7] = y[6:0];
        req_w[8*i +: 8] = w[7:0];
        req_h[7*i +: 7] = h[6:0];
        req_colour[3*i +: 3] = c[2:0];
    endtask
    // Called in the grant cycle; runs through FILL (pause high for FILL cycles [ps, ps+pl))
    // and returns in the DONE cycle, or after a cycle budget
    task automatic scan(input int ps, input int pl);
        ncycles = 0;
        nplots = 0;
        tick;
        while (done == 3'b000 && ncycles < 64) begin
            pause = (ncycles >= ps && ncycles < ps + pl);
            #1;
            if (vga_plot) begin
                if (nplots < 16) begin
                    px[nplots] = int'(vga_x);
                    py[nplots] = int'(vga_y);
                    pc[nplots] = int'(vga_colour);
                end
                nplots++;
            end
            ncycles++;
            tick;
        end
        pause = 1'b0;
    endtask
    task automatic wait_gnt;
        for (int n = 0; n < 10 && gnt == 3'b000; n++) tick;
    endtask
    initial begin
        reset = 1'b1; req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0;
        req_colour = '0; pause = 1'b0;
        tick; tick;
        reset = 1'b0;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_plot", 32'(vga_plot), 0);
        check("rst_xyc", {vga_x, 1'b0, vga_y, 13'd0, vga_colour}, 0);
        // single 3x2 request
        set_req(0, 10, 5, 3, 2, 4); req = 3'b001;
        tick;
        check("single_gnt", 32'(gnt), 32'b001);
        check("single_busy", 32'(busy), 1);
        check("single_gnt_plot", 32'(vga_plot), 0);
        req = 3'b000;
        scan(0, 0);
        check("single_cycles", ncycles, 6);
        check("single_plots", nplots, 6);
        for (int k = 0; k < 6; k++) begin
            check("single_x", px[k], 10 + k % 3);
            check("single_y", py[k], 5 + k / 3);
            check("single_col", pc[k], 4);
        end
        check("single_done", 32'(done), 32'b001);
        check("single_done_plot", 32'(vga_plot), 0);
        tick;
        check("single_idle_busy", 32'(busy), 0);
        check("single_idle_done", 32'(done), 0);
        // ptr is now 1: requester 2 beats requester 0
        set_req(0, 1, 1, 1, 1, 1); set_req(2, 2, 2, 1, 1, 2); req = 3'b101;
        tick;
        check("ptr_first_gnt", 32'(gnt), 32'b100);
        req[2] = 1'b0;
        scan(0, 0);
        check("ptr_first_plot", px[0], 2);
        check("ptr_first_done", 32'(done), 32'b100);
        wait_gnt;
        check("ptr_second_gnt", 32'(gnt), 32'b001);
        req[0] = 1'b0;
        scan(0, 0);
        check("ptr_second_done", 32'(done), 32'b001);
        tick;
        // clipping at the bottom-right corner
        set_req(1, 158, 119, 4, 2, 5); req = 3'b010;
        tick;
        check("clip_gnt", 32'(gnt), 32'b010);
        req = 3'b000;
        scan(0, 0);
        check("clip_cycles", ncycles, 8);
        check("clip_plots", nplots, 2);
        check("clip_x0", px[0], 158);
        check("clip_x1", px[1], 159);
        check("clip_y0", py[0], 119);
        check("clip_y1", py[1], 119);
        check("clip_done", 32'(done), 32'b010);
        tick;
        // empty rectangle: gnt then done back to back
        set_req(0, 3, 3, 0, 2, 7); req = 3'b001;
        tick;
        check("empty_gnt", 32'(gnt), 32'b001);
        check("empty_gnt_plot", 32'(vga_plot), 0);
        req = 3'b000;
        tick;
        check("empty_done", 32'(done), 32'b001);
        check("empty_done_plot", 32'(vga_plot), 0);
        tick;
        check("empty_idle", 32'(busy), 0);
        // 2x2 with a five-cycle pause after the first pixel
        set_req(2, 40, 50, 2, 2, 6); req = 3'b100;
        tick;
        check("pause_gnt", 32'(gnt), 32'b100);
        req = 3'b000;
        scan(1, 5);
        check("pause_cycles", ncycles, 9);
        check("pause_plots", nplots, 4);
        for (int k = 0; k < 4; k++) begin
            check("pause_x", px[k], 40 + k % 2);
            check("pause_y", py[k], 50 + k / 2);
        end
        check("pause_done", 32'(done), 32'b100);
        tick;
        // contention after reset: strict 0,1,2 rotation
        reset = 1'b1; tick; reset = 1'b0;
        set_req(0, 0, 0, 1, 1, 1); set_req(1, 1, 0, 1, 1, 2); set_req(2, 2, 0, 1, 1, 3);
        req = 3'b111;
        for (int g = 0; g < 6; g++) begin
            wait_gnt;
            check("cont_gnt", 32'(gnt), 32'(3'b001 << (g % 3)));
            check("cont_overlap", 32'(done), 0);
            tick;
            check("cont_plot_x", {31'd0, vga_plot} + 32'(vga_x), 32'(1 + g % 3));
            tick;
            check("cont_done", 32'(done), 32'(3'b001 << (g % 3)));
        end
        req = 3'b000;
        tick;
        // reset during FILL of a 4x4 after seven plots
        set_req(0, 20, 30, 4, 4, 2); req = 3'b001;
        tick;
        check("rstmid_gnt", 32'(gnt), 32'b001);
        req = 3'b000;
        for (int k = 0; k < 7; k++) begin
            tick;
            check("rstmid_plot_x", {31'd0, vga_plot} * 256 + 32'(vga_x), 256 + 20 + k % 4);
        end
        tick;
        reset = 1'b1;
        #1;
        check("rstmid_plot_drop", 32'(vga_plot), 0);
        tick;
        reset = 1'b0;
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_xy", {vga_x, 1'b0, vga_y, 13'd0, vga_colour}, 0);
        for (int k = 0; k < 3; k++) begin
            check("rstmid_no_done", 32'(done), 0);
            tick;
        end
        set_req(1, 7, 8, 1, 1, 3); req = 3'b010;
        tick;
        check("rstmid_regrant", 32'(gnt), 32'b010);
        req = 3'b000;
        scan(0, 0);
        check("rstmid_regrant_plots", nplots, 1);
        check("rstmid_regrant_x", px[0], 7);
        check("rstmid_regrant_done", 32'(done), 32'b010);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
